// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares the single write port of the async FIFO write side among NREQ
//   requesters. Whole bursts are granted round-robin; each burst is capped at
//   MAX_BURST accepted beats and honours the write controller's full flag.
//
// Ports
//   w_clk   write-domain clock, rising edge
//   wrst    synchronous active-high reset
//   req     per-requester write request, held while data is valid
//   last    per-requester end-of-burst marker, qualified by req
//   data    packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full    FIFO full flag (backpressure)
//   gnt     registered one-hot grant, zero when idle
//   ack     beat-accepted strobe: gnt & req & ~full
//   w_en    FIFO write enable (|ack)
//   w_data  data of the granted requester, zero when no grant
//   owner   index of the granted requester, holds last owner when idle
//   busy    high while a burst is in progress
module fifo_write_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          w_clk,
  input  logic                          wrst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               last,
  input  logic [NREQ*DATA_WIDTH-1:0]    data,
  input  logic                          full,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               ack,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NREQ)-1:0]       owner,
  output logic                          busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [OW-1:0]   owner_r, owner_s;
  logic [OW-1:0]   rr_r, rr_s;
  logic [OW-1:0]   rr_inc_s;
  logic [OW-1:0]   sel_s;
  logic            sel_found_s;
  logic [CW-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic            beat_s;
  logic            exit_s;
  int              idx_s;

  // Round-robin search: first requester with req set, starting at rr.
  always_comb begin
    sel_found_s = 1'b0;
    sel_s       = {OW{1'b0}};
    idx_s       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = int'(rr_r) + k;
      idx_s = (idx_s >= NREQ) ? (idx_s - NREQ) : idx_s;
      if (!sel_found_s && req[idx_s]) begin
        sel_found_s = 1'b1;
        sel_s       = OW'(idx_s);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Beat acceptance and write-port outputs; nothing is written during reset.
  always_comb begin
    beat_s = (state_r == ST_BURST) && req[owner_r] && !full && !wrst;
    ack    = gnt_r & req & {NREQ{~full & ~wrst}};
    w_en   = |ack;
    if ((|gnt_r) && !wrst) begin
      w_data = data[owner_r*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      w_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state logic for the IDLE/BURST machine and its bookkeeping.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    owner_s   = owner_r;
    cnt_s     = cnt_r;
    rr_s      = rr_r;
    cnt_inc_s = cnt_r + CW'(1);
    rr_inc_s  = (owner_r == OW'(NREQ - 1)) ? {OW{1'b0}} : (owner_r + OW'(1));
    // Burst ends on last, on reaching the cap, or when the owner lets go.
    exit_s    = (beat_s && (last[owner_r] || (cnt_inc_s == CW'(MAX_BURST))))
                || !req[owner_r];
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_s = ST_BURST;
          gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << sel_s;
          owner_s = sel_s;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (beat_s) begin
          cnt_s = cnt_inc_s;
        end else begin
          cnt_s = cnt_r;
        end
        if (exit_s) begin
          state_s = ST_IDLE;
          gnt_s   = {NREQ{1'b0}};
          rr_s    = rr_inc_s;
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {NREQ{1'b0}};
      end
    endcase
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      state_r <= ST_IDLE;
      gnt_r   <= {NREQ{1'b0}};
      owner_r <= {OW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      rr_r    <= {OW{1'b0}};
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      owner_r <= owner_s;
      cnt_r   <= cnt_s;
      rr_r    <= rr_s;
    end
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign busy  = (state_r == ST_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic                 clk = 1'b0;
  logic                 wrst;
  logic [NREQ-1:0]      req, last;
  logic [NREQ*DW-1:0]   data;
  logic                 full;
  logic [NREQ-1:0]      gnt, ack;
  logic                 w_en;
  logic [DW-1:0]        w_data;
  logic [1:0]           owner;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  // Reference model: burst-level view of the arbiter
  bit m_busy;
  int m_owner, m_cnt, m_rr;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .w_clk(clk), .wrst(wrst), .req(req), .last(last), .data(data), .full(full),
    .gnt(gnt), .ack(ack), .w_en(w_en), .w_data(w_data), .owner(owner), .busy(busy)
  );

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Advance the model by the rules for this cycle's inputs, then clock.
  task automatic tick();
    int  o;
    bit  beat;
    if (wrst) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        o = (m_rr + k) % NREQ;
        if (req[o]) begin
          m_busy = 1; m_owner = o; m_cnt = 0;
          break;
        end
      end
    end else begin
      o    = m_owner;
      beat = req[o] && !full;
      if (beat) m_cnt++;
      if ((beat && (last[o] || m_cnt == MAXB)) || !req[o]) begin
        m_busy = 0;
        m_rr   = (o + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1; req = '0; last = '0; full = 1'b0;
    tick();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1; req = 4'b1111; last = 4'b0000; full = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 ||
        w_en !== 1'b0 || ack !== 4'b0000 || w_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: gnt=%b busy=%b owner=%0d w_en=%b ack=%b w_data=%h, required all zero",
               gnt, busy, owner, w_en, ack, w_data);
    end
    tick();
    wrst = 1'b0;
  endtask

  task automatic test_single_burst();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      req  = (c <= 3) ? 4'b0001 : (c == 5) ? 4'b0011 : 4'b0000;
      last = (c == 3) ? 4'b0001 : 4'b0000;
      data[7:0] = 8'hA0 + 8'(c);
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (gnt !== 4'b0000 || w_en !== 1'b0) begin
          errors++;
          $display("FAIL single_arb: gnt=%b w_en=%b, required 0000 0", gnt, w_en);
        end
      end else if (c <= 3) begin
        checks++;
        if (gnt !== 4'b0001 || w_en !== 1'b1 || ack !== 4'b0001 || w_data !== 8'hA0 + 8'(c)) begin
          errors++;
          $display("FAIL single_beat%0d: gnt=%b w_en=%b ack=%b w_data=%h, required 0001 1 0001 %h",
                   c, gnt, w_en, ack, w_data, 8'hA0 + 8'(c));
        end
      end else if (c == 4) begin
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || w_en !== 1'b0 || owner !== 2'd0) begin
          errors++;
          $display("FAIL single_end: gnt=%b busy=%b w_en=%b owner=%0d, required 0000 0 0 0",
                   gnt, busy, w_en, owner);
        end
      end else if (c == 6) begin
        checks++;
        if (gnt !== 4'b0010) begin
          errors++;
          $display("FAIL single_rr: gnt=%b, required 0010", gnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int order[$]; int beats[$]; int gaps[$];
    int gap = 0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] prev = '0;
    do_reset();
    req = 4'b1111; last = 4'b0000; full = 1'b0;
    for (int c = 0; c < 25; c++) begin
      data = $urandom;
      @(negedge clk);
      if (gnt !== 4'b0000 && prev === 4'b0000) begin
        order.push_back(onehot_idx(gnt));
        beats.push_back(0);
        if (order.size() > 1) gaps.push_back(gap);
        gap = 0;
      end
      if (gnt === 4'b0000) gap++;
      if (w_en === 1'b1 && beats.size() > 0) beats[beats.size()-1]++;
      prev = gnt;
      tick();
    end
    req = '0;
    tick();
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d bursts, required 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i] || beats[i] != MAXB) begin
          errors++;
          $display("FAIL rr_burst%0d: owner=%0d beats=%0d, required %0d %0d",
                   i, order[i], beats[i], exp_order[i], MAXB);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gaps[i] != 1) begin
          errors++;
          $display("FAIL rr_gap%0d: dead=%0d, required 1", i, gaps[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_w[4] = '{8'h11, 8'h15, 8'h16, 8'h17};
    do_reset();
    last = '0;
    for (int c = 0; c <= 9; c++) begin
      req  = (c < 8) ? 4'b0100 : 4'b0000;
      full = (c >= 2 && c <= 4);
      data[2*DW +: DW] = 8'h10 + 8'(c);
      @(negedge clk);
      if (w_en === 1'b1) got.push_back(w_data);
      if (full) begin
        checks++;
        if (w_en !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0100) begin
          errors++;
          $display("FAIL stall_c%0d: w_en=%b ack=%b gnt=%b, required 0 0000 0100", c, w_en, ack, gnt);
        end
      end
      if (c == 8) begin
        checks++;
        if (gnt !== 4'b0000) begin
          errors++;
          $display("FAIL stall_end: gnt=%b, required 0000", gnt);
        end
      end
      tick();
    end
    full = 1'b0;
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL stall_words: got %0d words, required 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL stall_word%0d: got %h, required %h", i, got[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_abandon();
    int words = 0;
    do_reset();
    last = '0; full = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      req = (c <= 2) ? 4'b0010 : (c == 4) ? 4'b0110 : 4'b0000;
      data = $urandom;
      @(negedge clk);
      if (w_en === 1'b1 && c <= 3) words++;
      if (c == 4) begin
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
          errors++;
          $display("FAIL abandon_end: gnt=%b busy=%b, required 0000 0", gnt, busy);
        end
      end
      if (c == 5) begin
        checks++;
        if (gnt !== 4'b0100) begin
          errors++;
          $display("FAIL abandon_rr: gnt=%b, required 0100", gnt);
        end
      end
      tick();
    end
    checks++;
    if (words != 2) begin
      errors++;
      $display("FAIL abandon_words: got %0d, required 2", words);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    last = '0; full = 1'b0; req = 4'b1111;
    for (int c = 0; c <= 4; c++) begin
      wrst = (c == 2);
      data = $urandom;
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (w_en !== 1'b0 || ack !== 4'b0000 || w_data !== 8'h00) begin
          errors++;
          $display("FAIL midrst_cycle: w_en=%b ack=%b w_data=%h, required 0 0000 00", w_en, ack, w_data);
        end
      end
      if (c == 3) begin
        checks++;
        if (gnt !== 4'b0000 || w_en !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
          errors++;
          $display("FAIL midrst_after: gnt=%b w_en=%b busy=%b owner=%0d, required 0000 0 0 0",
                   gnt, w_en, busy, owner);
        end
      end
      if (c == 4) begin
        checks++;
        if (gnt !== 4'b0001) begin
          errors++;
          $display("FAIL midrst_regrant: gnt=%b, required 0001", gnt);
        end
      end
      tick();
    end
    wrst = 1'b0; req = '0;
    tick();
    tick();
  endtask

  task automatic test_sparse();
    int order[$];
    int bad = 0;
    logic [NREQ-1:0] prev = '0;
    do_reset();
    req = 4'b1010; last = '0; full = 1'b0;
    for (int c = 0; c < 15; c++) begin
      data = $urandom;
      @(negedge clk);
      if (gnt !== 4'b0000 && prev === 4'b0000) order.push_back(onehot_idx(gnt));
      if (gnt[0] || gnt[2] || ack[0] || ack[2]) bad++;
      prev = gnt;
      tick();
    end
    req = '0;
    tick();
    checks++;
    if (order.size() != 3 || order[0] != 1 || order[1] != 3 || order[2] != 1) begin
      errors++;
      $display("FAIL sparse_order: got %p, required 1 3 1", order);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sparse_isolation: %0d cycles with gnt/ack on 0 or 2, required 0", bad);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] e_gnt, e_ack;
    logic [DW-1:0]   e_data;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        last[i] = ($urandom_range(0, 3) == 0);
        data[i*DW +: DW] = DW'($urandom);
      end
      full = ($urandom_range(0, 3) == 0);
      wrst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      e_gnt = '0;
      if (m_busy) e_gnt[m_owner] = 1'b1;
      e_ack  = wrst ? '0 : (e_gnt & req & {NREQ{~full}});
      e_data = (m_busy && !wrst) ? data[m_owner*DW +: DW] : '0;
      checks++;
      if (gnt !== e_gnt || ack !== e_ack || w_en !== (|e_ack) || w_data !== e_data ||
          busy !== m_busy || owner !== 2'(m_owner)) begin
        errors++;
        $display("FAIL random_c%0d: gnt=%b ack=%b w_en=%b w_data=%h busy=%b owner=%0d, required %b %b %b %h %b %0d",
                 c, gnt, ack, w_en, w_data, busy, owner, e_gnt, e_ack, |e_ack, e_data, m_busy, m_owner);
      end
      tick();
    end
    wrst = 1'b0; req = '0;
    tick();
  endtask

  initial begin
    wrst = 1'b1; req = '0; last = '0; full = 1'b0; data = '0;
    m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_abandon();
    test_mid_reset();
    test_sparse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
